lanes_rx_align_ctrl: RTL and testbench
======================================

# lanes_rx_align_ctrl

Receive-side alignment controller that sequences the two-lane deserializer. It drives the deserializer enable and checks the sync header of every deserialized symbol on both lanes. It slips the symbol boundary by one bit, by pulsing the deserializer enable low, until headers are consistently valid, and reports lock to the logical layer. It sits between link training (which requests receive) and the deserializer/descrambler path, and re-acquires alignment on header errors or speed changes.

## Interface
- GOOD_LOCK, 64: consecutive good symbols in VERIFY required to declare lock (2..255).
- BAD_LIMIT, 8: bad symbols within one window in LOCKED that force loss of lock (1..255).
- WINDOW, 64: symbol count of the LOCKED error-monitor window (BAD_LIMIT..255).
- MAX_SLIP, 132: slips without reaching lock before `align_timeout` pulses (1..255).

Ports:
- clk  in  1  single clock; also clocks the deserializer.
- rst  in  1  asynchronous, active-high reset.
- rx_en  in  1  receive request from link training; level.
- gen_speed  in  2  00=GEN4, 01=GEN3, 10=GEN2, 11 treated as GEN4; same encoding as the deserializer.
- sym_valid  in  1  deserializer `enable_dec`; level.
- sym_strobe  in  1  deserializer `descr_rst`; one-cycle pulse per symbol period.
- lane_0_hdr  in  4  bits [3:0] of lane 0 parallel word (first-received bits).
- lane_1_hdr  in  4  bits [3:0] of lane 1 parallel word.
- enable_deser  out  1  deserializer enable; registered.
- rx_locked  out  1  alignment achieved; registered level.
- align_timeout  out  1  one-cycle pulse when MAX_SLIP slips elapse without lock.
- slip_count  out  8  slips since last entry to HUNT from IDLE/restart; saturating.

## Operation
- Symbol event: the cycle where `sym_strobe && sym_valid`. The header is sampled only on such a cycle; all other cycles are ignored.
- Header good, per lane, by speed:
  - GEN2: hdr[1:0] is 01 or 10.
  - GEN3: hdr[3:0] is 0101 or 1010.
  - GEN4: always good (no sync header).
- A symbol is good only if both lanes are good.
- States: IDLE, HUNT, VERIFY, LOCKED, SLIP.
- IDLE: `enable_deser`=0, counters cleared. Goes to HUNT when `rx_en`=1.
- HUNT: `enable_deser`=1.
  - Good symbol -> VERIFY with good_cnt=1.
  - Bad symbol -> SLIP.
  - GEN4 -> LOCKED on the first symbol event.
- VERIFY:
  - Good symbol -> good_cnt+1; at good_cnt==GOOD_LOCK -> LOCKED.
  - Bad symbol -> SLIP.
- LOCKED: `rx_locked`=1.
  - win_cnt increments per symbol event; bad_cnt increments per bad symbol.
  - When win_cnt reaches WINDOW, both counters clear.
  - bad_cnt reaching BAD_LIMIT -> SLIP, and `rx_locked` drops.
- SLIP: `enable_deser`=0 for exactly one cycle. This resets the deserializer framing, so the boundary shifts by one bit. Then:
  - slip_count+1, saturating at 255.
  - Return to HUNT.
  - If slips since last lock/timeout reach MAX_SLIP, pulse `align_timeout`, clear the internal slip-timeout counter, and keep hunting.
- Restart: a `gen_speed` change (compared with a registered copy) while not in IDLE -> SLIP path with all counters cleared, including slip_count.
- `rx_en`=0 in any state -> IDLE on the next edge; `enable_deser`=0 that edge.
- Priority, highest first: rst, then `rx_en`=0, then `gen_speed` change, then state logic.

## Timing
- Reset values: `enable_deser`=0, `rx_locked`=0, `align_timeout`=0, `slip_count`=0, state IDLE, all counters 0, registered speed = 00.
- All outputs are registered.
- IDLE->HUNT: `enable_deser` rises 1 cycle after `rx_en` rises.
- Decision latency: the state change, and any `rx_locked` change, is visible the cycle after the deciding symbol event.
- SLIP low pulse: exactly 1 clk, starting the cycle after the bad symbol event. `enable_deser` is high again on the following cycle.
- Symbol events during SLIP, or within the same cycle as a transition into IDLE, are ignored.
- Deserializer latency after re-enable: `sym_valid` stays low for about two symbol periods. The controller simply waits in HUNT; there is no HUNT timeout.
- Counter widths: 8 bits each, with compares as `==`. good_cnt saturates; win_cnt and bad_cnt never exceed their limits.
- `align_timeout` pulse coincides with the SLIP exit cycle.
- Asynchronous reset mid-operation: all outputs go to reset values immediately, and there is no SLIP pulse on reset release.

## Test plan
- GEN2 lock: `rx_en`=1, both headers 01 on every event -> VERIFY after the 1st event, `rx_locked`=1 one cycle after the 64th good event, slip_count=0.
- Slip sequencing: GEN3 with lane_1_hdr=0000 for 3 events, then 1010 -> three single-cycle `enable_deser` lows, slip_count=3, then lock after 64 good events.
- Loss of lock: locked GEN2; inject 8 bad events within 64 symbols -> `rx_locked` falls one cycle after the 8th bad event and a SLIP pulse occurs. Injecting only 7 bad per window keeps lock.
- Timeout: GEN2 with headers always 11 and MAX_SLIP=4 -> `align_timeout` pulses on the 4th and 8th slips, `rx_locked` stays 0, slip_count=8.
- Speed change and rx_en: while locked at GEN3, change to GEN2 -> one-cycle `enable_deser` low, slip_count=0, `rx_locked`=0, relock. Dropping `rx_en` -> `enable_deser`=0 the next cycle.
- GEN4 and reset: GEN4 -> lock on the first symbol event. Asserting rst mid-VERIFY -> all outputs 0 asynchronously, with IDLE held until `rx_en` is seen after release.

Source files
------------

// File: rtl/lanes_rx_align_ctrl.sv
// rtl/lanes_rx_align_ctrl.sv - two-lane receive symbol alignment controller
module lanes_rx_align_ctrl #(
  parameter int unsigned GOOD_LOCK = 64,
  parameter int unsigned BAD_LIMIT = 8,
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned MAX_SLIP  = 132
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic [1:0] gen_speed,
  input  logic       sym_valid,
  input  logic       sym_strobe,
  input  logic [3:0] lane_0_hdr,
  input  logic [3:0] lane_1_hdr,
  output logic       enable_deser,
  output logic       rx_locked,
  output logic       align_timeout,
  output logic [7:0] slip_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HUNT   = 3'd1,
    S_VERIFY = 3'd2,
    S_LOCKED = 3'd3,
    S_SLIP   = 3'd4
  } state_t;

  localparam logic [7:0] C_GOOD_LOCK = 8'(GOOD_LOCK);
  localparam logic [7:0] C_BAD_LIMIT = 8'(BAD_LIMIT);
  localparam logic [7:0] C_WINDOW    = 8'(WINDOW);
  localparam logic [7:0] C_MAX_SLIP  = 8'(MAX_SLIP);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_speed;
  logic [7:0] r_good_cnt, w_good_cnt_nxt;
  logic [7:0] r_win_cnt, w_win_cnt_nxt;
  logic [7:0] r_bad_cnt, w_bad_cnt_nxt;
  logic [7:0] r_slip_tmo, w_slip_tmo_nxt;
  logic [7:0] r_slip_count, w_slip_count_nxt;
  logic       r_restart, w_restart_nxt;
  logic       r_enable, w_enable_nxt;
  logic       r_locked, w_locked_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic       w_evt;
  logic       w_gen4;
  logic       w_good;
  logic       w_speed_chg;
  logic [7:0] w_good_inc;
  logic [7:0] w_win_inc;
  logic [7:0] w_bad_inc;
  logic [7:0] w_slip_inc;
  logic [7:0] w_tmo_inc;

  // Per-lane sync header check for the currently registered speed.
  function automatic logic hdr_ok(input logic [3:0] h, input logic [1:0] spd);
    logic ok;
    case (spd)
      2'b01:   ok = (h == 4'b0101) || (h == 4'b1010);
      2'b10:   ok = h[1] ^ h[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign w_evt       = sym_strobe & sym_valid;
  assign w_gen4      = (r_speed == 2'b00) || (r_speed == 2'b11);
  assign w_good      = hdr_ok(lane_0_hdr, r_speed) & hdr_ok(lane_1_hdr, r_speed);
  assign w_speed_chg = (gen_speed != r_speed);
  assign w_good_inc  = (r_good_cnt == 8'hFF) ? r_good_cnt : r_good_cnt + 8'd1;
  assign w_win_inc   = r_win_cnt + 8'd1;
  assign w_bad_inc   = r_bad_cnt + {7'd0, ~w_good};
  assign w_slip_inc  = (r_slip_count == 8'hFF) ? r_slip_count : r_slip_count + 8'd1;
  assign w_tmo_inc   = r_slip_tmo + 8'd1;

  // Register every piece of state; speed copy tracks the input every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_speed      <= 2'b00;
      r_good_cnt   <= 8'd0;
      r_win_cnt    <= 8'd0;
      r_bad_cnt    <= 8'd0;
      r_slip_tmo   <= 8'd0;
      r_slip_count <= 8'd0;
      r_restart    <= 1'b0;
      r_enable     <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_speed      <= gen_speed;
      r_good_cnt   <= w_good_cnt_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_bad_cnt    <= w_bad_cnt_nxt;
      r_slip_tmo   <= w_slip_tmo_nxt;
      r_slip_count <= w_slip_count_nxt;
      r_restart    <= w_restart_nxt;
      r_enable     <= w_enable_nxt;
      r_locked     <= w_locked_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // Next-state and next-output decisions: rx_en drop, then speed restart, then per-state rules.
  always_comb begin
    w_state_nxt      = r_state;
    w_good_cnt_nxt   = r_good_cnt;
    w_win_cnt_nxt    = r_win_cnt;
    w_bad_cnt_nxt    = r_bad_cnt;
    w_slip_tmo_nxt   = r_slip_tmo;
    w_slip_count_nxt = r_slip_count;
    w_restart_nxt    = r_restart;
    w_enable_nxt     = r_enable;
    w_locked_nxt     = r_locked;
    w_timeout_nxt    = 1'b0;

    if (!rx_en) begin
      w_state_nxt      = S_IDLE;
      w_enable_nxt     = 1'b0;
      w_locked_nxt     = 1'b0;
      w_good_cnt_nxt   = 8'd0;
      w_win_cnt_nxt    = 8'd0;
      w_bad_cnt_nxt    = 8'd0;
      w_slip_tmo_nxt   = 8'd0;
      w_slip_count_nxt = 8'd0;
      w_restart_nxt    = 1'b0;
    end else if ((r_state != S_IDLE) && w_speed_chg) begin
      // Restart slip: reframes the deserializer but is not counted as an alignment slip.
      w_state_nxt      = S_SLIP;
      w_enable_nxt     = 1'b0;
      w_locked_nxt     = 1'b0;
      w_good_cnt_nxt   = 8'd0;
      w_win_cnt_nxt    = 8'd0;
      w_bad_cnt_nxt    = 8'd0;
      w_slip_tmo_nxt   = 8'd0;
      w_slip_count_nxt = 8'd0;
      w_restart_nxt    = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_HUNT;
          w_enable_nxt = 1'b1;
        end
        S_HUNT, S_VERIFY: begin
          if (w_evt) begin
            if ((r_state == S_HUNT && w_gen4) ||
                (w_good && r_state == S_VERIFY && w_good_inc == C_GOOD_LOCK)) begin
              w_state_nxt    = S_LOCKED;
              w_locked_nxt   = 1'b1;
              w_good_cnt_nxt = 8'd0;
              w_win_cnt_nxt  = 8'd0;
              w_bad_cnt_nxt  = 8'd0;
              w_slip_tmo_nxt = 8'd0;
            end else if (w_good) begin
              w_state_nxt    = S_VERIFY;
              w_good_cnt_nxt = (r_state == S_HUNT) ? 8'd1 : w_good_inc;
            end else begin
              w_state_nxt    = S_SLIP;
              w_enable_nxt   = 1'b0;
              w_good_cnt_nxt = 8'd0;
              w_restart_nxt  = 1'b0;
            end
          end
        end
        S_LOCKED: begin
          if (w_evt) begin
            if (w_bad_inc == C_BAD_LIMIT) begin
              w_state_nxt   = S_SLIP;
              w_enable_nxt  = 1'b0;
              w_locked_nxt  = 1'b0;
              w_win_cnt_nxt = 8'd0;
              w_bad_cnt_nxt = 8'd0;
              w_restart_nxt = 1'b0;
            end else if (w_win_inc == C_WINDOW) begin
              w_win_cnt_nxt = 8'd0;
              w_bad_cnt_nxt = 8'd0;
            end else begin
              w_win_cnt_nxt = w_win_inc;
              w_bad_cnt_nxt = w_bad_inc;
            end
          end
        end
        S_SLIP: begin
          w_state_nxt   = S_HUNT;
          w_enable_nxt  = 1'b1;
          w_restart_nxt = 1'b0;
          if (!r_restart) begin
            w_slip_count_nxt = w_slip_inc;
            if (w_tmo_inc == C_MAX_SLIP) begin
              w_timeout_nxt  = 1'b1;
              w_slip_tmo_nxt = 8'd0;
            end else begin
              w_slip_tmo_nxt = w_tmo_inc;
            end
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_enable_nxt = 1'b0;
        end
      endcase
    end
  end

  assign enable_deser  = r_enable;
  assign rx_locked     = r_locked;
  assign align_timeout = r_timeout;
  assign slip_count    = r_slip_count;

endmodule

// File: tb/tb_lanes_rx_align_ctrl.sv
// tb/tb_lanes_rx_align_ctrl.sv - randomized self-checking bench with behavioural reference model
module tb_lanes_rx_align_ctrl;

  localparam int GOOD_LOCK = 64;
  localparam int BAD_LIMIT = 8;
  localparam int WINDOW    = 64;
  localparam int MAX_SLIP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic [1:0] gen_speed = 2'b00;
  logic       sym_valid = 1'b0;
  logic       sym_strobe = 1'b0;
  logic [3:0] lane_0_hdr = 4'h0;
  logic [3:0] lane_1_hdr = 4'h0;
  logic       enable_deser;
  logic       rx_locked;
  logic       align_timeout;
  logic [7:0] slip_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_to_seen = 0;
  bit cmp_on = 1'b0;

  lanes_rx_align_ctrl #(
    .GOOD_LOCK(GOOD_LOCK),
    .BAD_LIMIT(BAD_LIMIT),
    .WINDOW(WINDOW),
    .MAX_SLIP(MAX_SLIP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_en(rx_en),
    .gen_speed(gen_speed),
    .sym_valid(sym_valid),
    .sym_strobe(sym_strobe),
    .lane_0_hdr(lane_0_hdr),
    .lane_1_hdr(lane_1_hdr),
    .enable_deser(enable_deser),
    .rx_locked(rx_locked),
    .align_timeout(align_timeout),
    .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: link view of the receiver (enabled / slipping / run of good symbols / window history).
  logic       m_en = 1'b0;
  logic       m_lock = 1'b0;
  logic       m_to = 1'b0;
  logic [7:0] m_slips = 8'd0;
  logic [1:0] m_prev_speed = 2'b00;
  bit         m_active = 1'b0;
  bit         m_slipping = 1'b0;
  bit         m_restart = 1'b0;
  int         m_run = 0;
  int         m_since = 0;
  bit         m_hist[$];

  function automatic bit lane_ok(input logic [3:0] h, input logic [1:0] s);
    if (s == 2'b10) return (h[1:0] == 2'b01) || (h[1:0] == 2'b10);
    if (s == 2'b01) return (h == 4'b0101) || (h == 4'b1010);
    return 1'b1;
  endfunction

  function automatic int bad_total();
    int n = 0;
    foreach (m_hist[i]) n += int'(m_hist[i]);
    return n;
  endfunction

  task automatic model_clear();
    m_en = 1'b0; m_lock = 1'b0; m_to = 1'b0; m_slips = 8'd0; m_prev_speed = 2'b00;
    m_active = 1'b0; m_slipping = 1'b0; m_restart = 1'b0; m_run = 0; m_since = 0;
    m_hist.delete();
  endtask

  task automatic begin_slip(input bit restart);
    m_slipping = 1'b1; m_en = 1'b0; m_run = 0; m_hist.delete(); m_restart = restart;
  endtask

  task automatic take_lock();
    m_lock = 1'b1; m_run = 0; m_hist.delete(); m_since = 0;
  endtask

  task automatic model_step();
    bit evt;
    bit good;
    m_to = 1'b0;
    evt  = sym_strobe && sym_valid;
    good = lane_ok(lane_0_hdr, m_prev_speed) && lane_ok(lane_1_hdr, m_prev_speed);
    if (!rx_en) begin
      m_active = 1'b0; m_en = 1'b0; m_lock = 1'b0; m_slipping = 1'b0; m_restart = 1'b0;
      m_run = 0; m_hist.delete(); m_slips = 8'd0; m_since = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_en = 1'b1;
    end else if (gen_speed != m_prev_speed) begin
      begin_slip(1'b1); m_lock = 1'b0; m_slips = 8'd0; m_since = 0;
    end else if (m_slipping) begin
      m_slipping = 1'b0; m_en = 1'b1;
      if (!m_restart) begin
        if (m_slips != 8'd255) m_slips = m_slips + 8'd1;
        m_since++;
        if (m_since == MAX_SLIP) begin
          m_to = 1'b1; m_since = 0;
        end
      end
    end else if (evt) begin
      if (m_lock) begin
        m_hist.push_back(!good);
        if (bad_total() == BAD_LIMIT) begin
          begin_slip(1'b0); m_lock = 1'b0;
        end else if (m_hist.size() == WINDOW) begin
          m_hist.delete();
        end
      end else if (m_run == 0 && (m_prev_speed == 2'b00 || m_prev_speed == 2'b11)) begin
        take_lock();
      end else if (good) begin
        m_run++;
        if (m_run == GOOD_LOCK) take_lock();
      end else begin
        begin_slip(1'b0);
      end
    end
    m_prev_speed = gen_speed;
  endtask

  // Model advances on the same edges as the design.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (align_timeout === 1'b1) n_to_seen++;
      if (cmp_on) begin
        check("enable_deser", {7'd0, enable_deser}, {7'd0, m_en});
        check("rx_locked", {7'd0, rx_locked}, {7'd0, m_lock});
        check("align_timeout", {7'd0, align_timeout}, {7'd0, m_to});
        check("slip_count", slip_count, m_slips);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sym(input logic [3:0] h0, input logic [3:0] h1, input int gap);
    tick();
    sym_strobe = 1'b1; sym_valid = 1'b1; lane_0_hdr = h0; lane_1_hdr = h1;
    tick();
    sym_strobe = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [3:0] pick_hdr(input logic [1:0] s, input bit bad);
    logic [3:0] h;
    h = 4'($urandom);
    if (!bad) begin
      if (s == 2'b01) h = ($urandom_range(0, 1) == 1) ? 4'h5 : 4'hA;
      else if (s == 2'b10) h[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    end
    return h;
  endfunction

  initial begin
    int to0;
    int bad_rate;
    repeat (3) tick();
    check("reset_enable", {7'd0, enable_deser}, 8'd0);
    check("reset_locked", {7'd0, rx_locked}, 8'd0);
    check("reset_slip_count", slip_count, 8'd0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // GEN2 lock with header 01 on both lanes
    gen_speed = 2'b10;
    tick();
    rx_en = 1'b1;
    tick();
    check("idle_to_hunt_enable", {7'd0, enable_deser}, 8'd1);
    for (int i = 0; i < 63; i++) sym(4'h1, 4'h1, 2);
    check("gen2_not_locked_63", {7'd0, rx_locked}, 8'd0);
    sym(4'h1, 4'h1, 0);
    check("gen2_locked_64", {7'd0, rx_locked}, 8'd1);
    check("gen2_slip_count", slip_count, 8'd0);

    // Speed change GEN2 -> GEN3 while locked
    tick();
    gen_speed = 2'b01;
    tick();
    check("restart_enable_low", {7'd0, enable_deser}, 8'd0);
    check("restart_unlocked", {7'd0, rx_locked}, 8'd0);
    tick();
    check("restart_enable_high", {7'd0, enable_deser}, 8'd1);
    check("restart_slip_count", slip_count, 8'd0);

    // Slip sequencing at GEN3: three bad lane-1 headers, then good
    for (int i = 0; i < 3; i++) sym(4'hA, 4'h0, 3);
    check("gen3_slip_count", slip_count, 8'd3);
    for (int i = 0; i < 64; i++) sym(4'hA, 4'hA, 1);
    check("gen3_relock", {7'd0, rx_locked}, 8'd1);

    // Loss of lock at GEN2: 7 bad in one window keeps lock, 8 drops it
    tick();
    gen_speed = 2'b10;
    tick();
    tick();
    for (int i = 0; i < 64; i++) sym(4'h2, 4'h1, 1);
    check("gen2_relock", {7'd0, rx_locked}, 8'd1);
    for (int i = 0; i < 64; i++) sym((i % 9 == 0 && i < 63) ? 4'h3 : 4'h1, 4'h1, 1);
    check("seven_bad_keeps_lock", {7'd0, rx_locked}, 8'd1);
    for (int i = 0; i < 7; i++) sym(4'h3, 4'h1, 1);
    check("bad7_still_locked", {7'd0, rx_locked}, 8'd1);
    sym(4'h3, 4'h1, 0);
    check("bad8_lock_lost", {7'd0, rx_locked}, 8'd0);
    check("bad8_slip_pulse", {7'd0, enable_deser}, 8'd0);
    tick();
    check("bad8_slip_end", {7'd0, enable_deser}, 8'd1);

    // rx_en drop, then timeout with headers always 11
    rx_en = 1'b0;
    tick();
    check("rx_en_drop_enable", {7'd0, enable_deser}, 8'd0);
    rx_en = 1'b1;
    tick();
    to0 = n_to_seen;
    for (int i = 0; i < 8; i++) sym(4'h3, 4'h3, 3);
    tick();
    check("timeout_pulses", 8'(n_to_seen - to0), 8'd2);
    check("timeout_slip_count", slip_count, 8'd8);
    check("timeout_unlocked", {7'd0, rx_locked}, 8'd0);

    // GEN4 locks on first symbol event
    gen_speed = 2'b00;
    tick();
    tick();
    tick();
    sym(4'h0, 4'h0, 0);
    check("gen4_lock", {7'd0, rx_locked}, 8'd1);

    // Asynchronous reset mid-VERIFY
    gen_speed = 2'b10;
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) sym(4'h1, 4'h2, 1);
    check("verify_enable_before_rst", {7'd0, enable_deser}, 8'd1);
    rst = 1'b1;
    #1;
    check("async_rst_enable", {7'd0, enable_deser}, 8'd0);
    check("async_rst_locked", {7'd0, rx_locked}, 8'd0);
    check("async_rst_slip_count", slip_count, 8'd0);
    rx_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("idle_held_after_rst", {7'd0, enable_deser}, 8'd0);
    rx_en = 1'b1;
    tick();
    check("hunt_after_rst", {7'd0, enable_deser}, 8'd1);

    // Randomized traffic
    bad_rate = 150;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (c % 700 == 0) bad_rate = 150;
      if (c % 700 == 400) bad_rate = 2;
      if (c % 700 == 450) bad_rate = 150;
      if ($urandom_range(0, 399) == 0) rx_en = ~rx_en;
      else if (!rx_en && $urandom_range(0, 7) == 0) rx_en = 1'b1;
      if ($urandom_range(0, 499) == 0) gen_speed = 2'($urandom);
      sym_strobe = ($urandom_range(0, 3) == 0);
      sym_valid  = ($urandom_range(0, 7) != 0);
      lane_0_hdr = pick_hdr(gen_speed, $urandom_range(0, bad_rate - 1) == 0);
      lane_1_hdr = pick_hdr(gen_speed, $urandom_range(0, bad_rate - 1) == 0);
    end
    sym_strobe = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
